divint_mc: RTL and testbench



---
 rtl/divint_if.sv | 23 ++
 rtl/divint_mc.sv | 133 +++++++++++++
 tb/tb_divint_mc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/divint_if.sv
// Operand/result handshake bundle for the multicycle divider.
// master = operand producer / result consumer, slave = divider.
interface divint_if #(parameter int DATA_W = 8);
   logic              in_valid;
   logic              in_ready;
   logic              op_signed;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] quot;
   logic [DATA_W-1:0] rem;
   logic              div_by_zero;

   modport master (
      output in_valid, op_signed, op1, op2, out_ready,
      input  in_ready, out_valid, quot, rem, div_by_zero
   );
   modport slave (
      input  in_valid, op_signed, op1, op2, out_ready,
      output in_ready, out_valid, quot, rem, div_by_zero
   );
endinterface

// File: rtl/divint_mc.sv
// Multicycle restoring integer divider: one quotient bit per cycle on operand
// magnitudes, signs reapplied in FIX; truncating quotient, remainder takes dividend sign.
module divint_mc #(
   parameter int DATA_W = 8
) (
   input  logic     clk,
   input  logic     rst,
   divint_if.slave  bus
);
   localparam int CW = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            st_q, st_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;     // partial remainder (always < |op2|)
   logic [DATA_W-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [DATA_W-1:0] op1_q, op1_d;
   logic              sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
   logic [DATA_W-1:0] quot_q, quot_d, rem_q, rem_d;
   logic              dbz_q, dbz_d;
   logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;

   logic              s1, s2;
   logic [DATA_W-1:0] m1, m2;
   logic [DATA_W:0]   shifted, trial;

   always_comb begin
      st_d        = st_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      op1_d       = op1_q;
      sq_d        = sq_q;
      sr_d        = sr_q;
      dz_d        = dz_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      dbz_d       = dbz_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      s1          = bus.op_signed & bus.op1[DATA_W-1];
      s2          = bus.op_signed & bus.op2[DATA_W-1];
      m1          = s1 ? (~bus.op1 + 1'b1) : bus.op1;
      m2          = s2 ? (~bus.op2 + 1'b1) : bus.op2;
      shifted     = {acc_q, dvd_q[DATA_W-1]};
      // Remainder < divisor keeps the nonnegative trial within DATA_W bits,
      // so bit DATA_W of the difference is a reliable borrow.
      trial       = shifted - {1'b0, dvs_q};

      unique case (st_q)
         IDLE: if (bus.in_valid) begin
            dvd_d      = m1;
            dvs_d      = m2;
            acc_d      = '0;
            op1_d      = bus.op1;
            sq_d       = s1 ^ s2;
            sr_d       = s1;
            dz_d       = (bus.op2 == '0);
            cnt_d      = '0;
            in_ready_d = 1'b0;
            st_d       = CALC;
         end
         CALC: begin
            acc_d = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DATA_W - 1)) st_d = FIX;
         end
         FIX: begin
            if (dz_q) begin
               quot_d = '1;
               rem_d  = op1_q;
               dbz_d  = 1'b1;
            end else begin
               quot_d = sq_q ? (~dvd_q + 1'b1) : dvd_q;
               rem_d  = sr_q ? (~acc_q + 1'b1) : acc_q;
               dbz_d  = 1'b0;
            end
            out_valid_d = 1'b1;
            st_d        = DONE;
         end
         DONE: if (bus.out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            st_d        = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q        <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         op1_q       <= '0;
         sq_q        <= 1'b0;
         sr_q        <= 1'b0;
         dz_q        <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         op1_q       <= op1_d;
         sq_q        <= sq_d;
         sr_q        <= sr_d;
         dz_q        <= dz_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         dbz_q       <= dbz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.quot        = quot_q;
   assign bus.rem         = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divint_mc.sv
// Directed and model-checked stimulus for divint_mc at DATA_W=8.
module tb_divint_mc;
   localparam int W   = 8;
   localparam int LAT = W + 1;   // edges after the accept edge until out_valid is seen

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   divint_if #(.DATA_W(W)) bus();
   divint_mc #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Accept one operand set, then wait (bounded) for out_valid; lat = edges after accept.
   task automatic start_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat);
      int k;
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
      bus.in_valid = 1'b1; bus.op_signed = sg; bus.op1 = a; bus.op2 = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.op1 = 'x; bus.op2 = 'x;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic ack();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      int sa, sb;
      if (b == 0) begin
         q = '1; r = a; z = 1'b1;
      end else if (sg) begin
         sa = int'($signed(a)); sb = int'($signed(b));
         q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endtask

   task automatic op_check(input string tag, input logic sg, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input logic ez);
      int lat;
      start_op(sg, a, b, lat);
      chk({tag, "_lat"}, lat, LAT);
      chk({tag, "_quot"}, bus.quot, eq);
      chk({tag, "_rem"}, bus.rem, er);
      chk({tag, "_dbz"}, bus.div_by_zero, ez);
      ack();
   endtask

   initial begin
      logic [W-1:0] a, b, eq, er, hq, hr;
      logic         sg, ez;
      int           lat;

      bus.in_valid = 1'b0; bus.op_signed = 1'b0; bus.op1 = '0; bus.op2 = '0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_quot", bus.quot, 0);
      chk("rst_rem", bus.rem, 0);
      chk("rst_dbz", bus.div_by_zero, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      op_check("u100_7",   1'b0, 8'd100, 8'd7,  8'd14, 8'd2,  1'b0);
      op_check("sm100_7",  1'b1, 8'h9C,  8'd7,  8'hF2, 8'hFE, 1'b0);
      op_check("s100_m7",  1'b1, 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0);
      op_check("s_ovf",    1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0);
      op_check("uFF_1",    1'b0, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0);
      op_check("s_dz",     1'b1, 8'h85,  8'h00, 8'hFF, 8'h85, 1'b1);
      op_check("u_dz",     1'b0, 8'h85,  8'h00, 8'hFF, 8'h85, 1'b1);
      op_check("after_dz", 1'b0, 8'd9,   8'd4,  8'd2,  8'd1,  1'b0);
      op_check("smm",      1'b1, 8'hF9,  8'hFE, 8'd3,  8'hFF, 1'b0);

      // Backpressure: hold DONE for 20 cycles.
      start_op(1'b0, 8'd200, 8'd3, lat);
      chk("bp_lat", lat, LAT);
      hq = bus.quot; hr = bus.rem;
      chk("bp_quot0", hq, 8'd66);
      chk("bp_rem0", hr, 8'd2);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("bp_quot", bus.quot, hq);
         chk("bp_rem", bus.rem, hr);
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      ack();
      chk("ack_in_ready", bus.in_ready, 1);
      chk("ack_out_valid", bus.out_valid, 0);
      chk("hold_quot", bus.quot, 8'd66);

      // Reset during CALC: accept, let three iterations pass, then reset.
      bus.in_valid = 1'b1; bus.op_signed = 1'b0; bus.op1 = 8'd50; bus.op2 = 8'd6;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mrst_in_ready", bus.in_ready, 1);
      chk("mrst_out_valid", bus.out_valid, 0);
      chk("mrst_quot", bus.quot, 0);
      chk("mrst_rem", bus.rem, 0);
      chk("mrst_dbz", bus.div_by_zero, 0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("mrst_no_valid", bus.out_valid, 0);
      end
      op_check("post_rst", 1'b0, 8'd50, 8'd6, 8'd8, 8'd2, 1'b0);

      // Back-to-back random operations against the model.
      for (int i = 0; i < 2000; i++) begin
         sg = 1'(($urandom & 32'h1));
         a  = W'($urandom);
         b  = (($urandom & 32'hF) == 0) ? '0 : W'($urandom);
         model(sg, a, b, eq, er, ez);
         start_op(sg, a, b, lat);
         chk("rnd_lat", lat, LAT);
         chk("rnd_quot", bus.quot, eq);
         chk("rnd_rem", bus.rem, er);
         chk("rnd_dbz", bus.div_by_zero, ez);
         ack();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
